// File: rtl/t16_alu_pkg.sv
// Shared ALU typedefs for the 16-bit datapath plus the multiply sequencer state encoding.
// Imported by the ALU, the sequencer and its bus interface.
package t16_alu_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SLL  = 3'd5,
    ALU_SRL  = 3'd6,
    ALU_PASS = 3'd7
  } ALUOp;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } ALUFlags;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Core-op, multiply-request and multiply-response signals of the execute-stage ALU sequencer.
// The sequencer takes the slave view; the core / requester side takes the master view.
interface alu_mul_sequencer_if;
  import t16_alu_pkg::*;

  ALUOp                 core_op;
  logic [WIDTH-1:0]     core_s1;
  logic [WIDTH-1:0]     core_s2;
  logic [WIDTH-1:0]     core_d;
  ALUFlags              core_flags;
  logic                 core_grant;

  logic                 mul_valid;
  logic                 mul_ready;
  logic [WIDTH-1:0]     mul_a;
  logic [WIDTH-1:0]     mul_b;
  logic                 flush;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [2*WIDTH-1:0]   rsp_prod;
  logic                 rsp_z;
  logic                 rsp_hi_nz;

  modport slave (
    input  core_op, core_s1, core_s2, mul_valid, mul_a, mul_b, flush, rsp_ready,
    output core_d, core_flags, core_grant, mul_ready, rsp_valid, rsp_prod, rsp_z, rsp_hi_nz
  );

  modport master (
    output core_op, core_s1, core_s2, mul_valid, mul_a, mul_b, flush, rsp_ready,
    input  core_d, core_flags, core_grant, mul_ready, rsp_valid, rsp_prod, rsp_z, rsp_hi_nz
  );

endinterface

// File: rtl/alu_mul_sequencer_alu.sv
// Combinational 16-bit ALU. Carry is the adder carry-out (SUB: 1 = no borrow);
// overflow is signed overflow for ADD/SUB and 0 for logic/shift ops.
module alu_mul_sequencer_alu
  import t16_alu_pkg::*;
(
  input  ALUOp              op,
  input  logic [WIDTH-1:0]  s1,
  input  logic [WIDTH-1:0]  s2,
  output logic [WIDTH-1:0]  d,
  output ALUFlags           flags
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum     = '0;
    d       = '0;
    flags   = '0;
    case (op)
      ALU_ADD: begin
        sum     = {1'b0, s1} + {1'b0, s2};
        d       = sum[WIDTH-1:0];
        flags.c = sum[WIDTH];
        flags.v = (s1[WIDTH-1] == s2[WIDTH-1]) && (d[WIDTH-1] != s1[WIDTH-1]);
      end
      ALU_SUB: begin
        sum     = {1'b0, s1} + {1'b0, ~s2} + {{WIDTH{1'b0}}, 1'b1};
        d       = sum[WIDTH-1:0];
        flags.c = sum[WIDTH];
        flags.v = (s1[WIDTH-1] != s2[WIDTH-1]) && (d[WIDTH-1] != s1[WIDTH-1]);
      end
      ALU_AND:  d = s1 & s2;
      ALU_OR:   d = s1 | s2;
      ALU_XOR:  d = s1 ^ s2;
      ALU_SLL:  d = s1 << s2[3:0];
      ALU_SRL:  d = s1 >> s2[3:0];
      ALU_PASS: d = s2;
      default:  d = '0;
    endcase
    flags.z = (d == '0);
    flags.n = d[WIDTH-1];
  end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Execute-stage owner of the shared ALU: serves core ops, or borrows the ALU's adder for
// sixteen cycles to run an unsigned 16x16->32 shift-and-add multiply while the core stalls.
module alu_mul_sequencer
  import t16_alu_pkg::*;
#(
  parameter int WIDTH = t16_alu_pkg::WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_mul_sequencer_if.slave   bus
);

  seq_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0]    acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]    acc_lo_q, acc_lo_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [2*WIDTH-1:0]  rsp_prod_q, rsp_prod_d;
  logic                rsp_z_q, rsp_z_d;
  logic                rsp_hi_nz_q, rsp_hi_nz_d;

  ALUOp                alu_op;
  logic [WIDTH-1:0]    alu_s1;
  logic [WIDTH-1:0]    alu_s2;
  logic [WIDTH-1:0]    alu_d;
  ALUFlags             alu_flags;

  alu_mul_sequencer_alu u_alu (
    .op    (alu_op),
    .s1    (alu_s1),
    .s2    (alu_s2),
    .d     (alu_d),
    .flags (alu_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_prod_q  <= '0;
      rsp_z_q     <= 1'b0;
      rsp_hi_nz_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_prod_q  <= rsp_prod_d;
      rsp_z_q     <= rsp_z_d;
      rsp_hi_nz_q <= rsp_hi_nz_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mcand_d       = mcand_q;
    acc_hi_d      = acc_hi_q;
    acc_lo_d      = acc_lo_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_prod_d    = rsp_prod_q;
    rsp_z_d       = rsp_z_q;
    rsp_hi_nz_d   = rsp_hi_nz_q;
    alu_op        = bus.core_op;
    alu_s1        = bus.core_s1;
    alu_s2        = bus.core_s2;
    bus.mul_ready = (state_q == IDLE) && !bus.flush;
    bus.core_grant = (state_q != RUN);

    case (state_q)
      IDLE: begin
        if (bus.mul_valid && bus.mul_ready) begin
          mcand_d  = bus.mul_a;
          acc_lo_d = bus.mul_b;
          acc_hi_d = '0;
          cnt_d    = CNT_W'(WIDTH);
          state_d  = RUN;
        end
      end
      RUN: begin
        // The ALU adder does the partial-product add; its carry-out becomes bit 32 before the shift.
        alu_op   = ALU_ADD;
        alu_s1   = acc_hi_q;
        alu_s2   = acc_lo_q[0] ? mcand_q : '0;
        {acc_hi_d, acc_lo_d} = {alu_flags.c, alu_d, acc_lo_q[WIDTH-1:1]};
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_prod_d  = {acc_hi_d, acc_lo_d};
          rsp_z_d     = ({acc_hi_d, acc_lo_d} == '0);
          rsp_hi_nz_d = (acc_hi_d != '0);
        end
      end
      DONE: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase

    if (bus.flush && (state_q != IDLE)) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b0;
    end
  end

  assign bus.core_d     = alu_d;
  assign bus.core_flags = alu_flags;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_prod   = rsp_prod_q;
  assign bus.rsp_z      = rsp_z_q;
  assign bus.rsp_hi_nz  = rsp_hi_nz_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer: core ALU ops, multiply latency/products,
// response back-pressure, flush abort and asynchronous reset mid-multiply.
module tb_alu_mul_sequencer;
  import t16_alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_mul_sequencer_if bus ();

  alu_mul_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_op(input string tag, input ALUOp op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_d, input logic [3:0] exp_f);
    bus.core_op = op;
    bus.core_s1 = a;
    bus.core_s2 = b;
    #1;
    check({tag, "_d"}, {16'h0, bus.core_d}, {16'h0, exp_d});
    check({tag, "_flags"}, {28'h0, bus.core_flags}, {28'h0, exp_f});
    check({tag, "_grant"}, {31'h0, bus.core_grant}, 32'h1);
  endtask

  // Accept a multiply, wait for the response, optionally hold it under back-pressure, then drain.
  task automatic mul_run(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp, input int hold);
    int cyc;
    bus.mul_a     = a;
    bus.mul_b     = b;
    bus.mul_valid = 1'b1;
    #1;
    check({tag, "_ready"}, {31'h0, bus.mul_ready}, 32'h1);
    tick();
    bus.mul_valid = 1'b0;
    bus.mul_a     = 16'hDEAD;
    bus.mul_b     = 16'hBEEF;
    check({tag, "_stall"}, {31'h0, bus.core_grant}, 32'h0);
    cyc = 0;
    while (!bus.rsp_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, 32'd16);
    check({tag, "_prod"}, bus.rsp_prod, exp);
    check({tag, "_z"}, {31'h0, bus.rsp_z}, {31'h0, exp == 32'h0});
    check({tag, "_hi_nz"}, {31'h0, bus.rsp_hi_nz}, {31'h0, exp[31:16] != 16'h0});
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) tick();
      check({tag, "_hold_valid"}, {31'h0, bus.rsp_valid}, 32'h1);
      check({tag, "_hold_prod"}, bus.rsp_prod, exp);
      check({tag, "_hold_ready"}, {31'h0, bus.mul_ready}, 32'h0);
      check({tag, "_hold_grant"}, {31'h0, bus.core_grant}, 32'h1);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check({tag, "_drained"}, {31'h0, bus.rsp_valid}, 32'h0);
    check({tag, "_idle"}, {31'h0, bus.mul_ready}, 32'h1);
  endtask

  initial begin
    bus.core_op   = ALU_PASS;
    bus.core_s1   = 16'h0;
    bus.core_s2   = 16'h0;
    bus.mul_valid = 1'b0;
    bus.mul_a     = 16'h0;
    bus.mul_b     = 16'h0;
    bus.flush     = 1'b0;
    bus.rsp_ready = 1'b0;
    rst_n         = 1'b0;

    #2;
    check("rst_ready", {31'h0, bus.mul_ready}, 32'h1);
    check("rst_grant", {31'h0, bus.core_grant}, 32'h1);
    check("rst_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("rst_prod", bus.rsp_prod, 32'h0);
    check("rst_z", {31'h0, bus.rsp_z}, 32'h0);
    check("rst_hi_nz", {31'h0, bus.rsp_hi_nz}, 32'h0);
    #10;
    rst_n = 1'b1;
    tick();

    // Core ops while idle; flags packed {z,c,n,v}
    core_op("add_ovf", ALU_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011);
    core_op("add_wrap", ALU_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1100);
    core_op("sub_brw", ALU_SUB, 16'h0005, 16'h0007, 16'hFFFE, 4'b0010);
    core_op("and", ALU_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000);
    core_op("xor_z", ALU_XOR, 16'hA5A5, 16'hA5A5, 16'h0000, 4'b1000);

    mul_run("m3x5", 16'h0003, 16'h0005, 32'h0000_000F, 0);
    mul_run("mffff", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0);
    mul_run("m0", 16'h0000, 16'h1234, 32'h0000_0000, 0);
    mul_run("mhold", 16'h0003, 16'h0005, 32'h0000_000F, 5);
    mul_run("m8000", 16'h8000, 16'h0002, 32'h0001_0000, 0);

    // Core op left on the bus during a multiply must not disturb it
    bus.core_op = ALU_ADD;
    bus.core_s1 = 16'h7FFF;
    bus.core_s2 = 16'h0001;
    mul_run("mcore", 16'h1234, 16'h5678, 32'h0626_0060, 0);

    // Flush in IDLE blocks acceptance
    bus.mul_a     = 16'h0002;
    bus.mul_b     = 16'h0002;
    bus.mul_valid = 1'b1;
    bus.flush     = 1'b1;
    #1;
    check("flush_idle_ready", {31'h0, bus.mul_ready}, 32'h0);
    tick();
    bus.mul_valid = 1'b0;
    bus.flush     = 1'b0;
    #1;
    check("flush_idle_grant", {31'h0, bus.core_grant}, 32'h1);

    // Flush at RUN cycle 8
    bus.mul_a     = 16'h1234;
    bus.mul_b     = 16'h5678;
    bus.mul_valid = 1'b1;
    tick();
    bus.mul_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("flush_run_stall", {31'h0, bus.core_grant}, 32'h0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    check("flush_run_ready", {31'h0, bus.mul_ready}, 32'h1);
    check("flush_run_grant", {31'h0, bus.core_grant}, 32'h1);
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        if (bus.rsp_valid) seen++;
        tick();
      end
      check("flush_no_rsp", seen, 32'd0);
    end
    mul_run("mfresh", 16'h1234, 16'h5678, 32'h0626_0060, 0);

    // Asynchronous reset between edges mid-RUN
    bus.mul_a     = 16'hFFFF;
    bus.mul_b     = 16'hFFFF;
    bus.mul_valid = 1'b1;
    tick();
    bus.mul_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", {31'h0, bus.mul_ready}, 32'h1);
    check("arst_grant", {31'h0, bus.core_grant}, 32'h1);
    check("arst_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("arst_prod", bus.rsp_prod, 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    mul_run("m2x3", 16'h0002, 16'h0003, 32'h0000_0006, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
